// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: grants init/refresh/write/read engines exclusive use of the pins.
// Priority is refresh > write > read, with a counter that forces a read after repeated writes.
module sdram_arbit #(
  parameter int unsigned RD_MAX_WAIT = 4,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam int unsigned CntW = $clog2(RD_MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RD_MAX_WAIT);
  localparam logic [3:0] CmdNop = 4'b0111;

  typedef enum logic [2:0] {StInit, StArbit, StAref, StWrite, StRead} state_e;

  state_e          state_q, state_d;
  logic            aref_en_q, aref_en_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic [CntW-1:0] rd_wait_cnt_q, rd_wait_cnt_d;
  logic [3:0]      cmd;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StInit;
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_wait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      aref_en_q     <= aref_en_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      rd_wait_cnt_q <= rd_wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    aref_en_d     = aref_en_q;
    wr_en_d       = wr_en_q;
    rd_en_d       = rd_en_q;
    rd_wait_cnt_d = rd_wait_cnt_q;
    unique case (state_q)
      StInit: begin
        if (init_end) state_d = StArbit;
      end
      StArbit: begin
        if (aref_req) begin
          state_d   = StAref;
          aref_en_d = 1'b1;
          // An idle read line still clears the wait count; a pending read keeps it.
          if (!rd_req) rd_wait_cnt_d = '0;
        end else if (rd_req && (rd_wait_cnt_q == CntMax)) begin
          state_d       = StRead;
          rd_en_d       = 1'b1;
          rd_wait_cnt_d = '0;
        end else if (wr_req) begin
          state_d = StWrite;
          wr_en_d = 1'b1;
          if (!rd_req) begin
            rd_wait_cnt_d = '0;
          end else if (rd_wait_cnt_q != CntMax) begin
            rd_wait_cnt_d = rd_wait_cnt_q + 1'b1;
          end
        end else if (rd_req) begin
          state_d       = StRead;
          rd_en_d       = 1'b1;
          rd_wait_cnt_d = '0;
        end else begin
          rd_wait_cnt_d = '0;
        end
      end
      StAref: begin
        if (aref_end) begin
          state_d   = StArbit;
          aref_en_d = 1'b0;
        end
      end
      StWrite: begin
        if (wr_end) begin
          state_d = StArbit;
          wr_en_d = 1'b0;
        end
      end
      StRead: begin
        if (rd_end) begin
          state_d = StArbit;
          rd_en_d = 1'b0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    cmd        = CmdNop;
    sdram_ba   = 2'b11;
    sdram_addr = '1;
    unique case (state_q)
      StInit: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      StAref: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      StWrite: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      StRead: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = CmdNop;
        sdram_ba   = 2'b11;
        sdram_addr = '1;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_cke    = 1'b1;
  assign sdram_dq_oe  = (state_q == StWrite) & wr_sdram_en;
  assign sdram_dq_out = (state_q == StWrite) ? wr_sdram_data : '0;

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

endmodule
